// File: rtl/transposed_conv_pkg.sv
// Shared types and helpers for the stride-2x2 1x1 transposed convolution.
// Provides the FSM state enum, the binary32 zero word and counter sizing.
package transposed_conv_pkg;

    typedef enum logic [1:0] {
        ACCEPT,
        SECOND,
        ODD_ROW
    } state_t;

    localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

    // A count range of 1 still needs one physical bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fp32_mul.sv
// Combinational binary32 multiplier, round-to-nearest-even.
// Ports: i_a, i_b operands; o_p product. Denormals flush to signed zero.
module fp32_mul (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_p
);

    logic               w_sign;
    logic               w_a_zero, w_b_zero;
    logic               w_a_inf, w_b_inf;
    logic               w_a_nan, w_b_nan;
    logic [47:0]        w_prod;
    logic signed [9:0]  w_exp;
    logic signed [9:0]  w_exp_r;
    logic [22:0]        w_mant;
    logic               w_guard, w_sticky;
    logic [23:0]        w_mant_r;

    assign w_sign   = i_a[31] ^ i_b[31];
    assign w_a_zero = (i_a[30:23] == 8'h00);
    assign w_b_zero = (i_b[30:23] == 8'h00);
    assign w_a_inf  = (i_a[30:23] == 8'hFF) && (i_a[22:0] == 23'h0);
    assign w_b_inf  = (i_b[30:23] == 8'hFF) && (i_b[22:0] == 23'h0);
    assign w_a_nan  = (i_a[30:23] == 8'hFF) && (i_a[22:0] != 23'h0);
    assign w_b_nan  = (i_b[30:23] == 8'hFF) && (i_b[22:0] != 23'h0);
    assign w_prod   = {1'b1, i_a[22:0]} * {1'b1, i_b[22:0]};

    // Significand product lies in [1,4); bit 47 set means one extra exponent step.
    assign w_exp = $signed({2'b00, i_a[30:23]}) + $signed({2'b00, i_b[30:23]})
                 - 10'sd127 + $signed({9'b0, w_prod[47]});

    always_comb begin
        w_mant   = w_prod[45:23];
        w_guard  = w_prod[22];
        w_sticky = |w_prod[21:0];
        if (w_prod[47]) begin
            w_mant   = w_prod[46:24];
            w_guard  = w_prod[23];
            w_sticky = |w_prod[22:0];
        end
    end

    assign w_mant_r = {1'b0, w_mant} + {23'b0, w_guard & (w_sticky | w_mant[0])};
    // A rounding carry leaves the fraction at zero and bumps the exponent.
    assign w_exp_r  = w_exp + $signed({9'b0, w_mant_r[23]});

    always_comb begin
        o_p = {w_sign, w_exp_r[7:0], w_mant_r[22:0]};
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero))
            o_p = 32'h7FC0_0000;
        else if (w_a_inf || w_b_inf)
            o_p = {w_sign, 8'hFF, 23'h0};
        else if (w_a_zero || w_b_zero)
            o_p = {w_sign, 31'h0};
        else if (w_exp_r >= 10'sd255)
            o_p = {w_sign, 8'hFF, 23'h0};
        else if (w_exp_r <= 10'sd0)
            o_p = {w_sign, 31'h0};
    end

endmodule

// File: rtl/transposed_convolution2d_1x1_stride_2x2.sv
// Streaming 1x1 transposed convolution, stride 2x2: each pixel x Kernel,
// upsampled to a 2H x 2W raster. Ports: clk, rst (sync, active high),
// Data_In/Kernel/Valid_In/Ready_In in; Data_Out/Valid_Out/Last_Out out.
// UPSAMPLE_NEAREST_EN: replicate products (line buffer) instead of zero fill.
module transposed_convolution2d_1x1_stride_2x2
    import transposed_conv_pkg::*;
#(
    parameter int IMG_HEIGHT = 299,
    parameter int IMG_WIDHT  = 299
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Data_In,
    input  logic [31:0] Kernel,
    input  logic        Valid_In,
    output logic        Ready_In,
    output logic [31:0] Data_Out,
    output logic        Valid_Out,
    output logic        Last_Out
);

    localparam int CW = cnt_width(IMG_WIDHT);
    localparam int OW = cnt_width(2 * IMG_WIDHT);
    localparam int RW = cnt_width(IMG_HEIGHT);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDHT - 1);
    localparam logic [OW-1:0] ODD_LAST = OW'(2 * IMG_WIDHT - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    state_t        r_state;
    logic [CW-1:0] r_col;
    logic [OW-1:0] r_odd;
    logic [RW-1:0] r_row;
    logic [31:0]   w_prod;

    fp32_mul u_mul (
        .i_a (Data_In),
        .i_b (Kernel),
        .o_p (w_prod)
    );

    assign Ready_In = (r_state == ACCEPT);

`ifdef UPSAMPLE_NEAREST_EN
    logic [31:0]   r_prod;
    logic [31:0]   r_line [IMG_WIDHT];
    logic [CW-1:0] w_rep_idx;
    logic [31:0]   w_second_word;
    logic [31:0]   w_odd_word;

    // Each stored product is replayed on two consecutive odd-row cycles.
    assign w_rep_idx     = CW'(r_odd >> 1);
    assign w_second_word = r_prod;
    assign w_odd_word    = r_line[w_rep_idx];

    always_ff @(posedge clk) begin
        if (Ready_In && Valid_In) begin
            r_prod       <= w_prod;
            r_line[r_col] <= w_prod;
        end
    end
`else
    logic [31:0] w_second_word;
    logic [31:0] w_odd_word;

    assign w_second_word = FP32_ZERO;
    assign w_odd_word    = FP32_ZERO;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ACCEPT;
            r_col     <= '0;
            r_odd     <= '0;
            r_row     <= '0;
            Data_Out  <= FP32_ZERO;
            Valid_Out <= 1'b0;
            Last_Out  <= 1'b0;
        end else begin
            Last_Out <= 1'b0;
            unique case (r_state)
                ACCEPT: begin
                    Valid_Out <= Valid_In;
                    if (Valid_In) begin
                        Data_Out <= w_prod;
                        r_state  <= SECOND;
                    end
                end
                SECOND: begin
                    Valid_Out <= 1'b1;
                    Data_Out  <= w_second_word;
                    if (r_col == COL_LAST) begin
                        r_col   <= '0;
                        r_state <= ODD_ROW;
                    end else begin
                        r_col   <= r_col + 1'b1;
                        r_state <= ACCEPT;
                    end
                end
                ODD_ROW: begin
                    Valid_Out <= 1'b1;
                    Data_Out  <= w_odd_word;
                    if (r_odd == ODD_LAST) begin
                        r_odd   <= '0;
                        r_state <= ACCEPT;
                        if (r_row == ROW_LAST) begin
                            r_row    <= '0;
                            Last_Out <= 1'b1;
                        end else begin
                            r_row <= r_row + 1'b1;
                        end
                    end else begin
                        r_odd <= r_odd + 1'b1;
                    end
                end
                default: r_state <= ACCEPT;
            endcase
        end
    end

endmodule

// File: tb/tb_transposed_convolution2d_1x1_stride_2x2.sv
// Scoreboard bench for the stride-2x2 transposed convolution (2x2 image).
// Expected raster comes from a real-arithmetic reference multiply.
module tb_transposed_convolution2d_1x1_stride_2x2;

    localparam int H = 2;
    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Data_In, Kernel;
    logic        Valid_In;
    logic        Ready_In;
    logic [31:0] Data_Out;
    logic        Valid_Out, Last_Out;

    int errors = 0;
    int checks = 0;

    logic [32:0] q[$];
    logic [31:0] rowbuf [W];
    int m_col = 0;
    int m_row = 0;

    transposed_convolution2d_1x1_stride_2x2 #(
        .IMG_HEIGHT (H),
        .IMG_WIDHT  (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .Data_In   (Data_In),
        .Kernel    (Kernel),
        .Valid_In  (Valid_In),
        .Ready_In  (Ready_In),
        .Data_Out  (Data_Out),
        .Valid_Out (Valid_Out),
        .Last_Out  (Last_Out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic real mag(input logic [31:0] a);
        return (1.0 + real'(a[22:0]) / 8388608.0) * (2.0 ** (real'(int'(a[30:23])) - 127.0));
    endfunction

    // Exact double product, then a single RNE rounding down to binary32.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [63:0] d;
        logic [23:0] keep;
        logic [28:0] rem;
        int          e;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'h0 || b[30:23] == 8'h0) return {s, 31'h0};
        d    = $realtobits(mag(a) * mag(b));
        e    = int'(d[62:52]) - 1023 + 127;
        keep = {1'b0, d[51:29]};
        rem  = d[28:0];
        if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && keep[0])) keep = keep + 1;
        if (keep[23]) begin
            keep = '0;
            e++;
        end
        if (e >= 255) return {s, 8'hFF, 23'h0};
        if (e <= 0) return {s, 31'h0};
        return {s, e[7:0], keep[22:0]};
    endfunction

    function automatic logic [31:0] rand_f();
        int r;
        logic [7:0] e;
        r = $urandom_range(0, 15);
        if (r == 0) e = 8'h00;
        else if (r == 1) e = 8'($urandom_range(1, 254));
        else e = 8'($urandom_range(110, 144));
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    // Expected output raster for one accepted pixel.
    task automatic model_push(input logic [31:0] p);
        q.push_back({1'b0, p});
`ifdef UPSAMPLE_NEAREST_EN
        q.push_back({1'b0, p});
`else
        q.push_back({1'b0, 32'h0});
`endif
        rowbuf[m_col] = p;
        m_col++;
        if (m_col == W) begin
            m_col = 0;
            for (int i = 0; i < 2 * W; i++) begin
`ifdef UPSAMPLE_NEAREST_EN
                q.push_back({(i == 2 * W - 1) && (m_row == H - 1), rowbuf[i / 2]});
`else
                q.push_back({(i == 2 * W - 1) && (m_row == H - 1), 32'h0});
`endif
            end
            m_row = (m_row == H - 1) ? 0 : m_row + 1;
        end
    endtask

    // Entered and left at a negedge. While Ready_In is low after the
    // transfer, a bogus value is held on Data_In with Valid_In high.
    task automatic send(input logic [31:0] d, input logic [31:0] k, input int gap);
        int n;
        bit last_col;
        repeat (gap) begin
            Valid_In = 1'b0;
            Data_In  = $urandom;
            @(negedge clk);
        end
        Valid_In = 1'b1;
        Data_In  = d;
        Kernel   = k;
        n = 0;
        while (!Ready_In && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(n), 32'd0);
        last_col = (m_col == W - 1);
        @(posedge clk);
        model_push(ref_mul(d, k));
        @(negedge clk);
        n = 0;
        while (!Ready_In && n < 100) begin
            Valid_In = 1'b1;
            Data_In  = $urandom;
            Kernel   = $urandom;
            @(negedge clk);
            n++;
        end
        chk("ready_low_cycles", 32'(n), last_col ? 32'(2 * W + 1) : 32'd1);
        Valid_In = 1'b0;
    endtask

    task automatic chk_reset_vals();
        chk("rst_data", Data_Out, 32'h0);
        chk("rst_valid", {31'h0, Valid_Out}, 32'h0);
        chk("rst_last", {31'h0, Last_Out}, 32'h0);
        chk("rst_ready", {31'h0, Ready_In}, 32'h1);
    endtask

    task automatic frame4(input logic [31:0] k, input logic [31:0] a0, input logic [31:0] a1,
                          input logic [31:0] a2, input logic [31:0] a3, input int gap);
        send(a0, k, gap);
        send(a1, k, gap);
        send(a2, k, gap);
        send(a3, k, gap);
    endtask

    // Monitor: every pending expected word must appear back to back.
    initial begin
        logic [32:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (rst) continue;
            if (Valid_Out) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %h expected none", Data_Out);
                end else begin
                    e = q.pop_front();
                    chk("data_out", Data_Out, e[31:0]);
                    chk("last_out", {31'h0, Last_Out}, {31'h0, e[32]});
                end
            end else begin
                chk("idle_last", {31'h0, Last_Out}, 32'h0);
                chk("valid_gap_pending", 32'(q.size()), 32'd0);
            end
        end
    end

    initial begin
        int n;
        rst      = 1'b1;
        Valid_In = 1'b0;
        Data_In  = '0;
        Kernel   = '0;
        repeat (2) @(negedge clk);
        chk_reset_vals();
        rst = 1'b0;
        @(negedge clk);

        frame4(32'h4000_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 0);
        frame4(32'h4000_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 3);

        Valid_In = 1'b1;
        Data_In  = 32'h3F80_0000;
        Kernel   = 32'h4000_0000;
        @(posedge clk);
        model_push(ref_mul(32'h3F80_0000, 32'h4000_0000));
        @(negedge clk);
        Valid_In = 1'b0;
        rst      = 1'b1;
        q.delete();
        m_col = 0;
        m_row = 0;
        @(negedge clk);
        chk_reset_vals();
        rst = 1'b0;
        @(negedge clk);

        frame4(32'h4000_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 0);

        send(32'hBF80_0000, 32'h0000_0000, 0);
        send(32'h7F00_0000, 32'h4000_0000, 1);
        send(32'h0000_0001, 32'h3F80_0000, 0);
        send(32'h8040_0000, 32'h4000_0000, 2);

        for (int f = 0; f < 6; f++) begin
            for (int p = 0; p < H * W; p++)
                send(rand_f(), rand_f(), $urandom_range(0, 2));
        end

        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(q.size()), 32'd0);
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/transposed_convolution2d_1x1_stride_2x2.md
# transposed_convolution2d_1x1_stride_2x2

Streaming 1x1 transposed convolution with stride 2x2. It is the upsampling counterpart of the team's 1x1 stride-2x2 downsampling convolution. It accepts an IMG_HEIGHT x IMG_WIDHT raster of IEEE-754 binary32 pixels, multiplies each pixel by a scalar kernel, and emits a 2·IMG_HEIGHT x 2·IMG_WIDHT raster with zero insertion. It sits in the decoder path, feeding the next convolution stage, which has no backpressure.

## Interface
- IMG_HEIGHT, 299, input rows per frame (≥1)
- IMG_WIDHT, 299, input pixels per row (≥1)

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- Data_In  input  32  binary32 input pixel, raster order
- Kernel  input  32  binary32 weight; sampled on each accepted pixel
- Valid_In  input  1  Data_In valid
- Ready_In  output  1  block can accept; transfer = Valid_In & Ready_In
- Data_Out  output  32  binary32 output pixel, raster order
- Valid_Out  output  1  Data_Out valid; no downstream stall
- Last_Out  output  1  high with the final word of each output frame

## Operation
- States:
  - ACCEPT: Ready_In=1.
  - SECOND: emit the second word of an even-row pair.
  - ODD_ROW: emit a full zero row.
- ACCEPT, no transfer: stay in ACCEPT; next-cycle Valid_Out=0.
- ACCEPT, transfer: register Data_In*Kernel; next cycle Valid_Out=1, Data_Out=product; go to SECOND.
- SECOND: next cycle Valid_Out=1, Data_Out=32'h0000_0000; col++.
  - If col was IMG_WIDHT-1: col←0, go to ODD_ROW.
  - Else: go to ACCEPT.
- ODD_ROW: emit 2·IMG_WIDHT words of 32'h0 on consecutive cycles with Ready_In=0.
  - On the final word: row++ and go to ACCEPT.
  - If row was IMG_HEIGHT-1: assert Last_Out and wrap row←0.
- Multiply is binary32, round-to-nearest-even.
  - Zero operand gives ±0, with sign = XOR of operand signs.
  - Denormals are flushed to signed zero; overflow gives signed infinity.
- Counter widths:
  - col: $clog2(IMG_WIDHT) bits.
  - odd counter: $clog2(2·IMG_WIDHT) bits.
  - row: $clog2(IMG_HEIGHT) bits.
  - Parameter value 1 uses a 1-bit counter.
- Kernel may change between pixels; only the value at the transfer cycle is used.

## Timing
- Reset values: Data_Out=0, Valid_Out=0, Last_Out=0, Ready_In=1, state=ACCEPT, all counters=0.
- Reset mid-frame: abandons the frame; the first transfer after reset is pixel (0,0).
- Latency: transfer at cycle t → product on Data_Out at t+1 → zero word at t+2.
- Ready_In is combinational from the state register only, never from Valid_In.
- Throughput: with Valid_In held high, Valid_Out is continuously high. Each input row takes 4·IMG_WIDHT cycles: W accepts, W SECOND cycles, 2W ODD_ROW cycles.
- Valid_In while Ready_In=0: ignored; upstream must hold the data.
- Last_Out: exactly one cycle, coincident with the final ODD_ROW word.

## Configuration
- UPSAMPLE_NEAREST_EN:
  - Defined: nearest-neighbour upsampling.
    - SECOND repeats the product instead of 0.
    - ODD_ROW replays the preceding even output row from an IMG_WIDHT-deep product line buffer, each entry emitted twice.
  - Undefined: zero insertion as above; no line buffer is instantiated.
  - Handshake, latency and cycle counts are identical in both modes.

## Structure
- Package transposed_conv_pkg:
  - state enum (ACCEPT, SECOND, ODD_ROW)
  - FP32_ZERO constant
  - function computing counter widths
- Sub-module fp32_mul: combinational binary32 multiplier.
- Counters and FSM stay in the top.
- The line buffer is an inferred register array inside the UPSAMPLE_NEAREST_EN guard.

## Test plan
- Zero-insertion frame: IMG 2x2, Kernel=0x40000000 (2.0), inputs 1.0, 2.0, 3.0, 4.0 with Valid_In always high → 16 words: 0x40000000, 0, 0x40800000, 0, four zeros, 0x40C00000, 0, 0x41000000, 0, four zeros. Valid_Out is continuous and Last_Out is on word 16.
- Gapped input: insert 3 idle cycles before each pixel → output values are identical. Valid_Out is low only during the gaps, and Ready_In is low throughout each ODD_ROW.
- Stall compliance: hold Valid_In high with a new value while Ready_In=0 → that value is not consumed; the next transfer occurs at the ACCEPT cycle.
- Reset mid-frame: assert rst after the first output word → the next cycle shows all outputs at reset values. A fresh 2x2 frame then produces the full 16-word sequence.
- Arithmetic corners: inputs -1.0 x 0.0 → 0x80000000; 0x7F000000 x 2.0 → 0x7F800000; a denormal input → signed zero.
- Nearest mode (UPSAMPLE_NEAREST_EN): IMG 1x2, inputs 1.0 and 2.0, Kernel=1.0 → 0x3F800000 ×2, 0x40000000 ×2, then the same four words again, with Last_Out on word 8.
